// File: rtl/debug_link_pkg.sv
// Purpose: shared types and constants for the processor debug dump link.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package debug_link_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    SELECT,
    CAPTURE,
    BYTE0,
    BYTE1,
    BYTE2,
    WAIT_HOST,
    RESUME,
    WAIT_RELEASE
  } state_t;

  localparam logic [7:0] FRAME_HEADER_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_WORD       = 3;
  // Every word travels as BYTES_PER_WORD bytes regardless of WORD_SIZE.
  localparam int         CAPTURE_WIDTH        = 8 * BYTES_PER_WORD;

  // Bytes in one dump frame: header plus num_regs registers plus ip.
  function automatic int frame_length(input int num_regs);
    return 1 + BYTES_PER_WORD * (num_regs + 1);
  endfunction

endpackage

// File: rtl/debug_tx_byte_reg.sv
// Purpose: registered valid/ready byte output stage for the debug link.
// Latency: load is visible on tx_valid/tx_data one edge later.
// Backpressure: byte held until tx_valid && tx_ready; caller only loads when empty or on a handshake.
//
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   load, load_data       - present a new byte (takes priority over a handshake drop)
//   tx_valid, tx_ready    - byte handshake toward the sink
//   tx_data               - current byte, held while stalled and after it is taken
module debug_tx_byte_reg (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/processor_debug_reader.sv
// Purpose: on a processor wait-halt, dump r0..r(NUM_REGS-1) and ip as a framed byte stream, then resume on host request.
// Latency: tx_valid rises at the edge sampling wait_for_continue; 1 + 5*(NUM_REGS+1) edges to WAIT_HOST with tx_ready high.
// Backpressure: tx_valid && !tx_ready freezes tx_data and the FSM; host_continue is only looked at in WAIT_HOST.
//
// Ports:
//   clock, reset                               - system clock, synchronous active-high reset
//   wait_for_continue, wait_continue_execution - processor halt status / one-cycle resume pulse
//   debug_get_param, debug_reg_addr            - debug read strobe and address (NUM_REGS selects ip)
//   debug_data_out                             - combinational debug read data from the processor
//   tx_valid, tx_ready, tx_data                - framed byte stream toward the host link
//   host_continue                              - host permission to resume
//   busy                                       - FSM is not idle
module processor_debug_reader
  import debug_link_pkg::*;
#(
  parameter int         WORD_SIZE    = 18,
  parameter int         NUM_REGS     = 8,
  parameter logic [7:0] FRAME_HEADER = FRAME_HEADER_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  input  logic                 host_continue,
  output logic                 busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS);

  state_t                   state;
  logic [3:0]               idx;
  logic [CAPTURE_WIDTH-1:0] word_q;
  logic [CAPTURE_WIDTH-1:0] capture_word;
  logic [CAPTURE_WIDTH-1:0] byte_src;
  logic [1:0]               byte_sel;
  logic                     tx_fire;
  logic                     tx_load;
  logic [7:0]               tx_load_data;

  assign capture_word = CAPTURE_WIDTH'(debug_data_out);

  // Byte 0 is loaded on the CAPTURE leaving edge straight from the debug
  // port, so it is in the output register the same edge word_q is latched.
  always_comb begin
    tx_fire  = tx_valid && tx_ready;
    byte_src = (state == CAPTURE) ? capture_word : word_q;
    byte_sel = 2'd0;
    tx_load  = 1'b0;
    case (state)
      IDLE:    tx_load = wait_for_continue;
      CAPTURE: tx_load = 1'b1;
      BYTE0: begin
        tx_load  = tx_fire;
        byte_sel = 2'd1;
      end
      BYTE1: begin
        tx_load  = tx_fire;
        byte_sel = 2'd2;
      end
      default: tx_load = 1'b0;
    endcase
    case (byte_sel)
      2'd0:    tx_load_data = byte_src[7:0];
      2'd1:    tx_load_data = byte_src[15:8];
      default: tx_load_data = byte_src[23:16];
    endcase
    if (state == IDLE) tx_load_data = FRAME_HEADER;
  end

  debug_tx_byte_reg u_tx_byte_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (tx_load),
    .load_data (tx_load_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      idx                     <= 4'd0;
      word_q                  <= '0;
      debug_get_param         <= 1'b0;
      debug_reg_addr          <= 4'd0;
      wait_continue_execution <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      wait_continue_execution <= 1'b0;
      case (state)
        IDLE: begin
          idx <= 4'd0;
          if (wait_for_continue) begin
            state <= HEADER;
            busy  <= 1'b1;
          end
        end
        HEADER: begin
          if (tx_fire) begin
            state           <= SELECT;
            debug_get_param <= 1'b1;
            debug_reg_addr  <= idx;
          end
        end
        // SELECT only gives the processor's read mux a full cycle to settle.
        SELECT: state <= CAPTURE;
        CAPTURE: begin
          word_q          <= capture_word;
          debug_get_param <= 1'b0;
          state           <= BYTE0;
        end
        BYTE0: if (tx_fire) state <= BYTE1;
        BYTE1: if (tx_fire) state <= BYTE2;
        BYTE2: begin
          if (tx_fire) begin
            if (idx == LAST_IDX) begin
              state <= WAIT_HOST;
            end else begin
              idx             <= idx + 4'd1;
              state           <= SELECT;
              debug_get_param <= 1'b1;
              debug_reg_addr  <= idx + 4'd1;
            end
          end
        end
        WAIT_HOST: if (host_continue) state <= RESUME;
        // The pulse is registered out of RESUME, so it is seen during the
        // first WAIT_RELEASE cycle.
        RESUME: begin
          wait_continue_execution <= 1'b1;
          state                   <= WAIT_RELEASE;
        end
        // Hold until the processor leaves the halt so one halt gives one frame.
        WAIT_RELEASE: begin
          if (!wait_for_continue) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_processor_debug_reader.sv
// Purpose: randomized self-checking bench for processor_debug_reader against a frame-level reference model.
// Latency: n/a.
// Backpressure: drives tx_ready held, stalled and random.
module tb_processor_debug_reader;
  import debug_link_pkg::*;

  localparam int WS   = 18;
  localparam int NR   = 8;
  localparam int FLEN = frame_length(NR);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wait_for_continue = 1'b0;
  logic          host_continue = 1'b0;
  logic          tx_ready = 1'b1;
  logic          wait_continue_execution;
  logic          debug_get_param;
  logic [3:0]    debug_reg_addr;
  logic [WS-1:0] debug_data_out;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          busy;

  // Processor model: register file r0..r7 at 0..7, ip at 8.
  logic [WS-1:0] regs [0:15];
  assign debug_data_out = debug_get_param ? regs[debug_reg_addr] : 18'h2A5A5;

  always #5 clock = ~clock;

  processor_debug_reader #(.WORD_SIZE(WS), .NUM_REGS(NR), .FRAME_HEADER(8'hA5)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .wait_for_continue       (wait_for_continue),
    .wait_continue_execution (wait_continue_execution),
    .debug_get_param         (debug_get_param),
    .debug_reg_addr          (debug_reg_addr),
    .debug_data_out          (debug_data_out),
    .tx_valid                (tx_valid),
    .tx_ready                (tx_ready),
    .tx_data                 (tx_data),
    .host_continue           (host_continue),
    .busy                    (busy)
  );

  // Bytes the sink accepts (handshake is taken at the following rising edge).
  logic [7:0] rxq [$];
  int         wce_cnt = 0;
  always @(negedge clock) if (!reset && tx_valid && tx_ready) rxq.push_back(tx_data);
  always @(negedge clock) if (wait_continue_execution) wce_cnt++;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q [$];

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Reference frame: header, then each word little-endian in 3 bytes.
  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int w = 0; w <= NR; w++)
      for (int b = 0; b < 3; b++)
        exp_q.push_back(8'((regs[w] >> (8 * b)) & 18'hFF));
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 16; i++) regs[i] = 18'($urandom);
  endtask

  task automatic wait_bytes(input int base, input int n, input int budget, output bit timed_out);
    int c = 0;
    timed_out = 1'b0;
    while (rxq.size() < base + n) begin
      tick();
      c++;
      if (c >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  // Host grants resume and keeps host_continue high for 8 edges with the
  // processor still halted; the processor then leaves the halt.
  task automatic release_cpu(output int first, output int pulses);
    int w0 = wce_cnt;
    first = -1;
    host_continue = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (wait_continue_execution && first < 0) first = i;
    end
    pulses = wce_cnt - w0;
    host_continue = 1'b0;
    wait_for_continue = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_for_continue = 1'b0;
    tick(3);
    tests_run += 6;
    if (wait_continue_execution !== 1'b0) begin tests_failed++; $display("FAIL reset wce: got %b want 0", wait_continue_execution); end
    if (debug_get_param !== 1'b0) begin tests_failed++; $display("FAIL reset get_param: got %b want 0", debug_get_param); end
    if (debug_reg_addr !== 4'd0) begin tests_failed++; $display("FAIL reset reg_addr: got %0d want 0", debug_reg_addr); end
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset tx_valid: got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset tx_data: got %02h want 00", tx_data); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b want 0", busy); end
    reset = 1'b0;
    tick(2);
    tests_run++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_no_halt: busy=%b tx_valid=%b want 0 0", busy, tx_valid); end
  endtask

  task automatic test_basic_frame();
    int base, c, lat, first, pulses, w0;
    for (int i = 0; i < NR; i++) regs[i] = 18'(i + 1);
    regs[NR] = 18'h00010;
    build_expected();
    base = rxq.size();
    w0 = wce_cnt;
    tx_ready = 1'b1;
    wait_for_continue = 1'b1;
    c = 0;
    while (!tx_valid && c < 10) begin tick(); c++; end
    tests_run++;
    if (c !== 1) begin tests_failed++; $display("FAIL basic tx_valid_latency: got %0d edges want 1", c); end
    tests_run++;
    if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL basic header: got %02h want a5", tx_data); end
    lat = 0;
    while (!(rxq.size() >= base + FLEN && !tx_valid) && lat < 200) begin tick(); lat++; end
    tests_run++;
    if (lat !== 1 + 5 * (NR + 1)) begin tests_failed++; $display("FAIL basic dump_latency: got %0d want %0d", lat, 1 + 5 * (NR + 1)); end
    tests_run++;
    if (busy !== 1'b1 || wce_cnt !== w0) begin tests_failed++; $display("FAIL basic wait_host: busy=%b pulses=%0d want 1 0", busy, wce_cnt - w0); end
    tests_run++;
    if (rxq.size() - base !== FLEN) begin tests_failed++; $display("FAIL basic frame_len: got %0d want %0d", rxq.size() - base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      tests_run++;
      if (rxq[base + i] !== exp_q[i]) begin tests_failed++; $display("FAIL basic byte%0d: got %02h want %02h", i, rxq[base + i], exp_q[i]); end
    end
    release_cpu(first, pulses);
    tests_run += 3;
    if (first !== 2) begin tests_failed++; $display("FAIL basic resume_latency: got %0d want 2", first); end
    if (pulses !== 1) begin tests_failed++; $display("FAIL basic resume_pulses: got %0d want 1", pulses); end
    if (busy !== 1'b0 || rxq.size() - base !== FLEN) begin tests_failed++; $display("FAIL basic after_release: busy=%b bytes=%0d want 0 %0d", busy, rxq.size() - base, FLEN); end
  endtask

  task automatic test_max_value();
    int base, first, pulses;
    bit to;
    randomize_regs();
    regs[3] = 18'h3FFFF;
    build_expected();
    base = rxq.size();
    wait_for_continue = 1'b1;
    wait_bytes(base, FLEN, 200, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL max timeout: got %0d bytes want %0d", rxq.size() - base, FLEN); end
    tests_run++;
    if ({rxq[base + 10], rxq[base + 11], rxq[base + 12]} !== 24'hFFFF03) begin
      tests_failed++;
      $display("FAIL max r3_bytes: got %02h %02h %02h want ff ff 03", rxq[base + 10], rxq[base + 11], rxq[base + 12]);
    end
    for (int w = 0; w <= NR; w++) begin
      tests_run++;
      if ((rxq[base + 3 + 3 * w] & 8'hFC) !== 8'h00) begin tests_failed++; $display("FAIL max byte2_upper w%0d: got %02h want 000000xx", w, rxq[base + 3 + 3 * w]); end
    end
    for (int i = 0; i < FLEN; i++) begin
      tests_run++;
      if (rxq[base + i] !== exp_q[i]) begin tests_failed++; $display("FAIL max byte%0d: got %02h want %02h", i, rxq[base + i], exp_q[i]); end
    end
    release_cpu(first, pulses);
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL max resume_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_backpressure();
    int base, first, pulses;
    bit to;
    randomize_regs();
    build_expected();
    base = rxq.size();
    tx_ready = 1'b1;
    wait_for_continue = 1'b1;
    wait_bytes(base, 2, 50, to);
    // Header and r0 byte 0 are taken; r0 byte 1 is now on the bus.
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[2]) begin tests_failed++; $display("FAIL stall cycle%0d: valid=%b data=%02h want 1 %02h", k, tx_valid, tx_data, exp_q[2]); end
    end
    tx_ready = 1'b1;
    wait_bytes(base, FLEN, 200, to);
    tick(4);
    tests_run++;
    if (rxq.size() - base !== FLEN) begin tests_failed++; $display("FAIL stall frame_len: got %0d want %0d", rxq.size() - base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      tests_run++;
      if (rxq[base + i] !== exp_q[i]) begin tests_failed++; $display("FAIL stall byte%0d: got %02h want %02h", i, rxq[base + i], exp_q[i]); end
    end
    release_cpu(first, pulses);
  endtask

  task automatic test_random_backpressure();
    int         base, c, first, pulses;
    bit         stalled;
    logic [7:0] held;
    randomize_regs();
    build_expected();
    base = rxq.size();
    wait_for_continue = 1'b1;
    c = 0;
    while (rxq.size() < base + FLEN && c < 2000) begin
      tx_ready = 1'($urandom_range(0, 1));
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      tick();
      c++;
      if (stalled) begin
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin tests_failed++; $display("FAIL rndbp hold: valid=%b data=%02h want 1 %02h", tx_valid, tx_data, held); end
      end
    end
    tx_ready = 1'b1;
    tick(4);
    tests_run++;
    if (rxq.size() - base !== FLEN) begin tests_failed++; $display("FAIL rndbp frame_len: got %0d want %0d", rxq.size() - base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      tests_run++;
      if (rxq[base + i] !== exp_q[i]) begin tests_failed++; $display("FAIL rndbp byte%0d: got %02h want %02h", i, rxq[base + i], exp_q[i]); end
    end
    release_cpu(first, pulses);
  endtask

  task automatic test_host_continue();
    int base, w0, first, pulses;
    bit to;
    randomize_regs();
    build_expected();
    base = rxq.size();
    w0 = wce_cnt;
    wait_for_continue = 1'b1;
    wait_bytes(base, 8, 100, to);
    host_continue = 1'b1;
    tick();
    host_continue = 1'b0;
    wait_bytes(base, FLEN, 200, to);
    tick(6);
    tests_run++;
    if (wce_cnt !== w0 || busy !== 1'b1) begin tests_failed++; $display("FAIL hostc early_resume: pulses=%0d busy=%b want 0 1", wce_cnt - w0, busy); end
    release_cpu(first, pulses);
    tests_run += 3;
    if (first !== 2) begin tests_failed++; $display("FAIL hostc resume_latency: got %0d want 2", first); end
    if (pulses !== 1) begin tests_failed++; $display("FAIL hostc held_pulses: got %0d want 1", pulses); end
    if (rxq.size() - base !== FLEN) begin tests_failed++; $display("FAIL hostc second_frame: got %0d bytes want %0d", rxq.size() - base, FLEN); end
  endtask

  task automatic test_rearm();
    int base, first, pulses;
    bit to;
    randomize_regs();
    build_expected();
    base = rxq.size();
    wait_for_continue = 1'b1;
    wait_bytes(base, FLEN, 200, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL rearm timeout: got %0d bytes want %0d", rxq.size() - base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      tests_run++;
      if (rxq[base + i] !== exp_q[i]) begin tests_failed++; $display("FAIL rearm byte%0d: got %02h want %02h", i, rxq[base + i], exp_q[i]); end
    end
    release_cpu(first, pulses);
  endtask

  task automatic test_wfc_drop();
    int base, w0;
    bit to;
    randomize_regs();
    build_expected();
    base = rxq.size();
    w0 = wce_cnt;
    wait_for_continue = 1'b1;
    wait_bytes(base, 10, 100, to);
    wait_for_continue = 1'b0;
    wait_bytes(base, FLEN, 200, to);
    tick(5);
    tests_run += 3;
    if (rxq.size() - base !== FLEN) begin tests_failed++; $display("FAIL drop frame_len: got %0d want %0d", rxq.size() - base, FLEN); end
    if (rxq[base + FLEN - 1] !== exp_q[FLEN - 1]) begin tests_failed++; $display("FAIL drop last_byte: got %02h want %02h", rxq[base + FLEN - 1], exp_q[FLEN - 1]); end
    if (busy !== 1'b1 || wce_cnt !== w0) begin tests_failed++; $display("FAIL drop wait_host: busy=%b pulses=%0d want 1 0", busy, wce_cnt - w0); end
    host_continue = 1'b1;
    tick(4);
    host_continue = 1'b0;
    tests_run++;
    if (wce_cnt !== w0 + 1 || busy !== 1'b0) begin tests_failed++; $display("FAIL drop resume: pulses=%0d busy=%b want 1 0", wce_cnt - w0, busy); end
  endtask

  task automatic test_reset_mid_dump();
    int base, base2, first, pulses;
    bit to;
    randomize_regs();
    build_expected();
    base = rxq.size();
    tx_ready = 1'b1;
    wait_for_continue = 1'b1;
    wait_bytes(base, 1 + 3 * 5 + 1, 200, to);
    // r5 byte 1 is now on the bus.
    reset = 1'b1;
    tick();
    tests_run++;
    if ({wait_continue_execution, debug_get_param, debug_reg_addr, tx_valid, tx_data, busy} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset outputs: wce=%b gp=%b addr=%0d valid=%b data=%02h busy=%b want all 0",
               wait_continue_execution, debug_get_param, debug_reg_addr, tx_valid, tx_data, busy);
    end
    reset = 1'b0;
    base2 = rxq.size();
    tests_run++;
    if (base2 - base !== 17) begin tests_failed++; $display("FAIL midreset stray_bytes: got %0d want 17", base2 - base); end
    wait_bytes(base2, FLEN, 200, to);
    for (int i = 0; i < FLEN; i++) begin
      tests_run++;
      if (rxq[base2 + i] !== exp_q[i]) begin tests_failed++; $display("FAIL midreset byte%0d: got %02h want %02h", i, rxq[base2 + i], exp_q[i]); end
    end
    release_cpu(first, pulses);
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL midreset resume_pulses: got %0d want 1", pulses); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    test_reset();
    test_basic_frame();
    test_max_value();
    test_backpressure();
    test_random_backpressure();
    test_host_continue();
    test_rearm();
    test_wfc_drop();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
